// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the RV32I MEM-stage access controller.
// Size encodings, FSM states, exception causes and lane helpers.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  rd;
  } acc_t;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      SZ_WORD: m = |off;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] be_gen(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_gen(
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{wdata[7:0]}};
      SZ_HALF: w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory port: req/gnt request phase, rvalid response phase.
// master = controller side, slave = memory side.
interface mem_access_ctrl_if;

  logic        dmem_req;
  logic        dmem_gnt;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_load_align_ext.sv
// Load data alignment: shift the addressed lane down, then
// sign- or zero-extend according to access size.
module load_align_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  always_comb begin
    sh     = rdata_i >> {off_i, 3'b000};
    data_o = sh;
    unique case (1'b1)
      (size_i == SZ_BYTE):
        data_o = {{24{sign_i & sh[7]}}, sh[7:0]};
      (size_i == SZ_HALF):
        data_o = {{16{sign_i & sh[15]}}, sh[15:0]};
      default:
        data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: single-outstanding load/store on the
// data-memory port with alignment and timeout exceptions.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.master  dmem,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_wdata_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_sign_i,
  input  logic [4:0]         req_rd_i,
  output logic               wb_valid_o,
  output logic [4:0]         wb_rd_o,
  output logic [31:0]        wb_data_o,
  output logic               exc_valid_o,
  output logic [1:0]         exc_cause_o,
  output logic [31:0]        exc_addr_o,
  output logic               stall_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  acc_t        acc_q;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        exc_valid_q;
  logic [1:0]  exc_cause_q;
  logic [31:0] exc_addr_q;

  logic        mis;
  logic        accept;
  logic        req_st;
  logic        tmo_hit;
  logic        ld_done;
  logic        tmo_fire;
  logic [31:0] ld_data;

  assign mis      = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign accept   = req_valid_i & req_ready_o;
  assign tmo_hit  = (cnt_q == CW'(TIMEOUT - 1));
  assign ld_done  = (state_q == S_WAIT) & dmem.dmem_rvalid;
  assign tmo_fire = (state_q == S_WAIT) & ~dmem.dmem_rvalid & tmo_hit;

  load_align_ext u_align (
    .rdata_i (dmem.dmem_rdata),
    .off_i   (acc_q.addr[1:0]),
    .size_i  (acc_q.size),
    .sign_i  (acc_q.sign),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && !mis) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d = '0;
        if (dmem.dmem_gnt)
          state_d = acc_q.we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (dmem.dmem_rvalid || tmo_hit) state_d = S_IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields are quiet outside REQ and stable from the capture regs.
  always_comb begin
    req_st          = (state_q == S_REQ);
    req_ready_o     = (state_q == S_IDLE);
    stall_o         = (state_q != S_IDLE) | (req_valid_i & ~mis);
    dmem.dmem_req   = req_st;
    dmem.dmem_we    = req_st & acc_q.we;
    dmem.dmem_addr  = req_st ? {acc_q.addr[31:2], 2'b00} : '0;
    dmem.dmem_be    = req_st ? be_gen(acc_q.size, acc_q.addr[1:0]) : '0;
    dmem.dmem_wdata = req_st ? wdata_gen(acc_q.size, acc_q.wdata) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= EXC_NONE;
      exc_addr_q  <= '0;
    end else begin
      if (accept) begin
        acc_q.we    <= req_we_i;
        acc_q.addr  <= req_addr_i;
        acc_q.wdata <= req_wdata_i;
        acc_q.size  <= req_size_i;
        acc_q.sign  <= req_sign_i;
        acc_q.rd    <= req_rd_i;
      end
      wb_valid_q <= ld_done;
      if (ld_done) begin
        wb_rd_q   <= acc_q.rd;
        wb_data_q <= ld_data;
      end
      exc_valid_q <= (accept & mis) | tmo_fire;
      if (accept && mis) begin
        exc_cause_q <= EXC_MISALIGN;
        exc_addr_q  <= req_addr_i;
      end else if (tmo_fire) begin
        exc_cause_q <= EXC_TIMEOUT;
        exc_addr_q  <= acc_q.addr;
      end
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_cause_o = exc_cause_q;
  assign exc_addr_o  = exc_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a writeback/exception
// scoreboard fed at stimulus time and drained on DUT pulses.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_sign = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        stall;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem        (bus.master),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_size_i  (req_size),
    .req_sign_i  (req_sign),
    .req_rd_i    (req_rd),
    .wb_valid_o  (wb_valid),
    .wb_rd_o     (wb_rd),
    .wb_data_o   (wb_data),
    .exc_valid_o (exc_valid),
    .exc_cause_o (exc_cause),
    .exc_addr_o  (exc_addr),
    .stall_o     (stall)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic [1:0]  cause;
    logic [31:0] addr;
  } ex_t;

  wb_t wbq[$];
  ex_t exq[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic sign, input logic [4:0] rd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_sign  = sign;
    req_rd    = rd;
  endtask

  task automatic drop_req;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    req_sign  = 1'b0;
    req_rd    = '0;
  endtask

  task automatic wait_wb(input string tag, input int budget, output int lat);
    wb_t e;
    lat = 0;
    while (!wb_valid && lat < budget) begin
      tick();
      lat++;
    end
    chkb({tag, ".wbv"}, wb_valid, 1'b1);
    if (wb_valid) begin
      chk({tag, ".wbq"}, 32'(wbq.size()), 32'd1);
      if (wbq.size() != 0) begin
        e = wbq.pop_front();
        chk({tag, ".rd"}, 32'(wb_rd), 32'(e.rd));
        chk({tag, ".data"}, wb_data, e.data);
      end
    end
  endtask

  task automatic wait_exc(input string tag, input int budget, output int lat);
    ex_t e;
    lat = 0;
    while (!exc_valid && lat < budget) begin
      tick();
      lat++;
    end
    chkb({tag, ".excv"}, exc_valid, 1'b1);
    if (exc_valid) begin
      chk({tag, ".exq"}, 32'(exq.size()), 32'd1);
      if (exq.size() != 0) begin
        e = exq.pop_front();
        chk({tag, ".cause"}, 32'(exc_cause), 32'(e.cause));
        chk({tag, ".addr"}, exc_addr, e.addr);
      end
    end
  endtask

  task automatic load_op(input string tag, input logic [31:0] addr,
                         input logic [1:0] size, input logic sign,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_data,
                         input int gdly, input int rdly);
    int lat;
    wbq.push_back({rd, exp_data});
    drive_req(1'b0, addr, 32'h0, size, sign, rd);
    #1;
    chkb({tag, ".stall0"}, stall, 1'b1);
    chkb({tag, ".rdy0"}, req_ready, 1'b1);
    tick();
    drop_req();
    chkb({tag, ".req"}, bus.dmem_req, 1'b1);
    chk({tag, ".be"}, 32'(bus.dmem_be), 32'(exp_be));
    chk({tag, ".addr"}, bus.dmem_addr, addr & 32'hFFFF_FFFC);
    chkb({tag, ".we"}, bus.dmem_we, 1'b0);
    repeat (gdly) tick();
    chkb({tag, ".reqheld"}, bus.dmem_req, 1'b1);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chkb({tag, ".reqdrop"}, bus.dmem_req, 1'b0);
    chkb({tag, ".stallw"}, stall, 1'b1);
    repeat (rdly) tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = rdata;
    tick();
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = '0;
    wait_wb(tag, 4, lat);
    chk({tag, ".lat"}, 32'(lat), 32'd0);
  endtask

  initial begin
    int   lat;
    int   n;
    logic stall_ok;

    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = '0;

    repeat (2) @(posedge clk);
    #1;
    chkb("rst.ready", req_ready, 1'b1);
    chkb("rst.req", bus.dmem_req, 1'b0);
    chkb("rst.wbv", wb_valid, 1'b0);
    chkb("rst.excv", exc_valid, 1'b0);
    chkb("rst.stall", stall, 1'b0);
    chk("rst.be", 32'(bus.dmem_be), 32'd0);
    rst_n = 1'b1;
    tick();

    load_op("ldb", 32'h0000_1003, SZ_BYTE, 1'b1, 5'd5, 32'h8000_0000,
            4'b1000, 32'hFFFF_FF80, 0, 0);
    load_op("ldhu", 32'h0000_2002, SZ_HALF, 1'b0, 5'd7, 32'hBEEF_0000,
            4'b1100, 32'h0000_BEEF, 0, 0);
    load_op("ldh", 32'h0000_8000, SZ_HALF, 1'b1, 5'd9, 32'h1234_8001,
            4'b0011, 32'hFFFF_8001, 1, 0);
    load_op("ldbu", 32'h0000_9001, SZ_BYTE, 1'b0, 5'd11, 32'h0000_F700,
            4'b0010, 32'h0000_00F7, 0, 2);
    load_op("ldw", 32'h0000_A004, SZ_WORD, 1'b1, 5'd31, 32'hDEAD_BEEF,
            4'b1111, 32'hDEAD_BEEF, 2, 3);

    drive_req(1'b1, 32'h0000_3002, 32'h1234_ABCD, SZ_HALF, 1'b0, 5'd0);
    tick();
    drop_req();
    chkb("sth.req", bus.dmem_req, 1'b1);
    chkb("sth.we", bus.dmem_we, 1'b1);
    chk("sth.be", 32'(bus.dmem_be), 32'b1100);
    chk("sth.wdata", bus.dmem_wdata, 32'hABCD_ABCD);
    chk("sth.addr", bus.dmem_addr, 32'h0000_3000);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chkb("sth.ready", req_ready, 1'b1);
    chkb("sth.reqdrop", bus.dmem_req, 1'b0);
    chkb("sth.nowb0", wb_valid, 1'b0);
    tick();
    chkb("sth.nowb1", wb_valid, 1'b0);

    drive_req(1'b1, 32'h0000_7001, 32'hAAAA_BB55, SZ_BYTE, 1'b0, 5'd0);
    tick();
    drop_req();
    repeat (2) tick();
    chkb("stb.req", bus.dmem_req, 1'b1);
    chk("stb.be", 32'(bus.dmem_be), 32'b0010);
    chk("stb.wdata", bus.dmem_wdata, 32'h5555_5555);
    chk("stb.addr", bus.dmem_addr, 32'h0000_7000);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chkb("stb.ready", req_ready, 1'b1);

    exq.push_back({EXC_MISALIGN, 32'h0000_4001});
    drive_req(1'b0, 32'h0000_4001, 32'h0, SZ_WORD, 1'b1, 5'd3);
    #1;
    chkb("misw.stall", stall, 1'b0);
    tick();
    drop_req();
    chkb("misw.req", bus.dmem_req, 1'b0);
    chkb("misw.ready", req_ready, 1'b1);
    wait_exc("misw", 2, lat);
    chk("misw.lat", 32'(lat), 32'd0);
    tick();
    chkb("misw.pulse", exc_valid, 1'b0);

    exq.push_back({EXC_MISALIGN, 32'h0000_4003});
    drive_req(1'b0, 32'h0000_4003, 32'h0, SZ_HALF, 1'b0, 5'd3);
    tick();
    drop_req();
    chkb("mish.req", bus.dmem_req, 1'b0);
    wait_exc("mish", 2, lat);

    exq.push_back({EXC_MISALIGN, 32'h0000_4000});
    drive_req(1'b1, 32'h0000_4000, 32'h0, SZ_ILL, 1'b0, 5'd0);
    #1;
    chkb("misi.stall", stall, 1'b0);
    tick();
    drop_req();
    chkb("misi.req", bus.dmem_req, 1'b0);
    wait_exc("misi", 2, lat);

    exq.push_back({EXC_TIMEOUT, 32'h0000_5000});
    drive_req(1'b0, 32'h0000_5000, 32'h0, SZ_WORD, 1'b0, 5'd4);
    tick();
    drop_req();
    stall_ok = 1'b1;
    repeat (5) begin
      stall_ok = stall_ok & stall & bus.dmem_req;
      tick();
    end
    chkb("tmo.holdoff", stall_ok, 1'b1);
    chkb("tmo.req", bus.dmem_req, 1'b1);
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    while (!exc_valid && n < 40) begin
      stall_ok = stall_ok & stall;
      tick();
      n++;
    end
    chkb("tmo.stall", stall_ok, 1'b1);
    chk("tmo.cycles", 32'(n), 32'd16);
    wait_exc("tmo", 0, lat);
    chkb("tmo.ready0", req_ready, 1'b1);
    chkb("tmo.nowb", wb_valid, 1'b0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hCAFE_F00D;
    tick();
    bus.dmem_rvalid = 1'b0;
    chkb("tmo.ready1", req_ready, 1'b1);
    tick();
    chkb("tmo.late", wb_valid, 1'b0);

    drive_req(1'b0, 32'h0000_6000, 32'h0, SZ_WORD, 1'b0, 5'd6);
    tick();
    drop_req();
    chkb("rstq.req", bus.dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("rstq.reqdrop", bus.dmem_req, 1'b0);
    chkb("rstq.ready", req_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    drive_req(1'b0, 32'h0000_B000, 32'h0, SZ_WORD, 1'b0, 5'd8);
    tick();
    drop_req();
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    chkb("rstw.stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("rstw.ready", req_ready, 1'b1);
    chkb("rstw.req", bus.dmem_req, 1'b0);
    chkb("rstw.stall0", stall, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1234_5678;
    tick();
    bus.dmem_rvalid = 1'b0;
    chkb("rstw.nowb0", wb_valid, 1'b0);
    tick();
    chkb("rstw.nowb1", wb_valid, 1'b0);

    chk("end.wbq", 32'(wbq.size()), 32'd0);
    chk("end.exq", 32'(exq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller for the RV32I MEM stage: accepts one load/store per request from the pipeline and drives a single-outstanding data-memory port with a req/gnt/rvalid handshake. Byte-enables and write-data lanes are generated from size and address offset. Load data is lane-aligned, then sign- or zero-extended. The pipeline is stalled while an access is in flight, and misaligned or timed-out accesses are reported as exceptions.

## Interface
- TIMEOUT, 16: maximum cycles spent in WAIT before a bus error is raised; must be ≥1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage presents an access.
- req_ready  out  1  controller accepts an access; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for narrow stores.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_rd  in  5  load destination register.
- dmem_req  out  1  memory request.
- dmem_gnt  in  1  memory accepts the request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word address, with bits [1:0] forced to 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- wb_valid  out  1  one-cycle pulse carrying load result.
- wb_rd  out  5  load destination register.
- wb_data  out  32  extended load data.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  2  01 = misaligned, 10 = bus timeout.
- exc_addr  out  32  faulting byte address.
- stall  out  1  pipeline hold.

## Operation
- States: IDLE, REQ, WAIT.
- Acceptance: a request is accepted when req_valid && req_ready. Address, size, sign, rd, we and wdata are captured in registers.
- Alignment check at acceptance:
  - half with addr[0]=1, word with addr[1:0]≠0, or size 11 are misaligned.
  - A misaligned access issues no memory request. The FSM stays in IDLE and pulses exc_valid with cause 01 on the next cycle.
- IDLE → REQ for an accepted aligned access.
- REQ: dmem_req=1 and dmem_* are held stable until dmem_gnt.
  - Store with gnt: go to IDLE; no wb pulse.
  - Load with gnt: go to WAIT.
- WAIT: a cycle counter starts at 0.
  - dmem_rvalid: go to IDLE.
  - Counter reaching TIMEOUT with no rvalid: go to IDLE and pulse exc cause 10. A late rvalid arriving in IDLE is ignored.
- Byte enables from off = addr[1:0]:
  - byte: 0001<<off.
  - half: 0011<<off.
  - word: 1111.
- Write data lanes: byte replicated ×4; half replicated ×2; word passed through.
- Load data:
  - Shift right by 8·off.
  - byte: extend bit 7.
  - half: extend bit 15.
  - word: pass through.
  - When req_sign=0, the upper bits are zeros.
- stall = (state≠IDLE) || (req_valid && !misaligned).
- Reset values (asynchronous): state IDLE, counter 0, and all outputs 0 except req_ready=1 (combinational from IDLE).

## Timing
- Load, zero-wait memory (gnt in the first REQ cycle, rvalid the cycle after): accept at T0, dmem_req at T1, rvalid at T2, wb_valid at T3. Latency is 3 cycles.
- Store: accept at T0, gnt at T1, back in IDLE at T2.
- wb_valid, wb_data, exc_* are registered single-cycle pulses.
- dmem_req drops in the cycle after gnt.
- gnt and rvalid in the same cycle as the request are not permitted; only one access is outstanding.
- Reset asserted mid-access deasserts dmem_req immediately and the transaction is abandoned.

## Structure
- A package mem_access_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum;
  - exception cause constants.
- One sub-module, load_align_ext, is purely combinational: it takes rdata, offset, size and sign and produces the extended word.
- The FSM, counter and lane generation live in mem_access_ctrl.

## Test plan
- Load byte, addr 0x1003, sign=1, rdata 0x80_00_00_00 → be 1000, wb_data 0xFFFF_FF80 three cycles after accept.
- Load half, addr 0x2002, sign=0, rdata 0xBEEF_0000 → wb_data 0x0000_BEEF.
- Store half, addr 0x3002, wdata 0x1234_ABCD → dmem_be 1100, dmem_wdata 0xABCD_ABCD, dmem_addr 0x3000; no wb pulse.
- Word load at 0x4001 → no dmem_req; exc_valid with cause 01 and exc_addr 0x4001; stall low.
- Load with gnt held off 5 cycles, then rvalid never returns → stall is held throughout; exc cause 10 fires after TIMEOUT WAIT cycles; req_ready is high the following cycle.
- rst_n pulled low while in WAIT → state IDLE and dmem_req=0 immediately; a stray rvalid after reset produces no wb pulse.
